// File: rtl/ext_sram_arbiter_pkg.sv
// Shared encodings for the external SRAM bus arbiter:
// FSM states, transfer sizes and requester ids.
package ext_sram_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_LO,
    S_A_HI,
    S_D_LO,
    S_A_LO2,
    S_D_HI,
    S_ACK
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/ext_sram_arbiter_rr_arb2.sv
// Two-way round-robin grant. Ports: clk, rst, req[1:0],
// advance/adv_id (move pointer away from adv_id), gnt_valid, gnt_id.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       adv_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (&req) gnt_id = ptr_q;
    else      gnt_id = req[1];
    ptr_d = ptr_q;
    if (advance) ptr_d = ~adv_id;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ext_sram_arbiter.sv
// Shares the 16-bit muxed SRAM pad bus between CPU (0) and DMA (1).
// Ports: req/addr/we/size/wdata/ack per requester, rdata, busy, pad
// side bus_out/bus_in/le_lo/le_hi/OEb/WEb_lo/WEb_hi/bus_dir.
// Option EXTMEM_WAIT_EN stretches data phases by WAIT_CYCLES.
module ext_sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [15:0] bus_out,
  input  logic [15:0] bus_in,
  output logic        le_lo,
  output logic        le_hi,
  output logic        OEb,
  output logic        WEb_lo,
  output logic        WEb_hi,
  output logic        bus_dir
);

  import ext_sram_arbiter_pkg::*;

  state_e      state_q, state_d;
  logic        gid_q, gid_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] bus_q, bus_d;
  logic        oeb_q, oeb_d;
  logic        webl_q, webl_d;
  logic        webh_q, webh_d;
  logic        lel_q, lel_d;
  logic        leh_q, leh_d;
  logic        dir_q, dir_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] hw;
  logic [7:0]  lane;
  logic        gnt_valid, gnt_id;
  logic        wait_done;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1, req0}),
    .advance   (state_q == S_ACK),
    .adv_id    (gid_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

`ifdef EXTMEM_WAIT_EN
  localparam int WCW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [WCW-1:0] wcnt_q, wcnt_d;

  assign wait_done = (wcnt_q == WCW'(WAIT_CYCLES));

  always_comb begin
    wcnt_d = '0;
    if ((state_q == S_D_LO || state_q == S_D_HI)
        && !wait_done)
      wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wcnt_q <= '0;
    else     wcnt_q <= wcnt_d;
  end
`else
  logic unused_wait;
  assign unused_wait = |WAIT_CYCLES;
  assign wait_done   = 1'b1;
`endif

  // Transfer sequencing; bus_in is sampled in the last data-phase cycle.
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lane    = addr_q[0] ? bus_in[15:8] : bus_in[7:0];
    unique case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          gid_d   = gnt_id;
          addr_d  = gnt_id ? addr1 : addr0;
          we_d    = gnt_id ? we1 : we0;
          size_d  = gnt_id ? size1 : size0;
          wdata_d = gnt_id ? wdata1 : wdata0;
          rdata_d = '0;
          state_d = S_A_LO;
        end
      end
      S_A_LO:  state_d = S_A_HI;
      S_A_HI:  state_d = S_D_LO;
      S_D_LO: begin
        if (wait_done) begin
          if (!we_q)
            rdata_d = (size_q == SZ_BYTE) ?
                      {24'h0, lane} : {16'h0, bus_in};
          state_d = (size_q == SZ_BYTE || size_q == SZ_HALF) ?
                    S_ACK : S_A_LO2;
        end
      end
      S_A_LO2: state_d = S_D_HI;
      S_D_HI: begin
        if (wait_done) begin
          if (!we_q) rdata_d[31:16] = bus_in;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pad strobes are registered from the next state so they line up
  // with the state they belong to.
  always_comb begin
    bus_d  = '0;
    oeb_d  = 1'b1;
    webl_d = 1'b1;
    webh_d = 1'b1;
    lel_d  = 1'b0;
    leh_d  = 1'b0;
    hw     = (state_d == S_D_HI) ? wdata_d[31:16] : wdata_d[15:0];
    unique case (state_d)
      S_A_LO: begin
        bus_d = addr_d[16:1];
        lel_d = 1'b1;
      end
      S_A_HI: begin
        bus_d = {1'b0, addr_d[31:17]};
        leh_d = 1'b1;
      end
      S_A_LO2: begin
        bus_d = addr_d[16:1] | 16'd1;
        lel_d = 1'b1;
      end
      S_D_LO, S_D_HI: begin
        if (!we_d) begin
          oeb_d = 1'b0;
        end else if (size_d == SZ_BYTE) begin
          bus_d  = addr_d[0] ? {wdata_d[7:0], 8'h00}
                             : {8'h00, wdata_d[7:0]};
          webh_d = ~addr_d[0];
          webl_d = addr_d[0];
        end else begin
          bus_d  = hw;
          webh_d = 1'b0;
          webl_d = 1'b0;
        end
      end
      default: ;
    endcase
    dir_d  = ~(lel_d | leh_d | ~webl_d | ~webh_d);
    ack0_d = (state_d == S_ACK) && (gid_d == REQ_CPU);
    ack1_d = (state_d == S_ACK) && (gid_d == REQ_DMA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gid_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bus_q   <= '0;
      oeb_q   <= 1'b1;
      webl_q  <= 1'b1;
      webh_q  <= 1'b1;
      lel_q   <= 1'b0;
      leh_q   <= 1'b0;
      dir_q   <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      bus_q   <= bus_d;
      oeb_q   <= oeb_d;
      webl_q  <= webl_d;
      webh_q  <= webh_d;
      lel_q   <= lel_d;
      leh_q   <= leh_d;
      dir_q   <= dir_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  // Latch enables are high-phase pulses for the '573 latches.
  assign le_lo   = lel_q & clk;
  assign le_hi   = leh_q & clk;
  assign bus_out = bus_q;
  assign OEb     = oeb_q;
  assign WEb_lo  = webl_q;
  assign WEb_hi  = webh_q;
  assign bus_dir = dir_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign rdata   = rdata_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ext_sram_arbiter.sv
// Directed bench for ext_sram_arbiter.
// Honours EXTMEM_WAIT_EN with WAIT_CYCLES = 2.
module tb_ext_sram_arbiter;

`ifdef EXTMEM_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif
  localparam int LAT_BH = 5 + W;
  localparam int LAT_W  = 7 + 2 * W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [1:0]  size0 = '0, size1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [15:0] bus_in = '0;
  logic        ack0, ack1, busy;
  logic [31:0] rdata;
  logic [15:0] bus_out;
  logic        le_lo, le_hi, OEb, WEb_lo, WEb_hi, bus_dir;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ext_sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .we0(we0), .we1(we1),
    .size0(size0), .size1(size1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .bus_out(bus_out), .bus_in(bus_in),
    .le_lo(le_lo), .le_hi(le_hi),
    .OEb(OEb), .WEb_lo(WEb_lo), .WEb_hi(WEb_hi),
    .bus_dir(bus_dir)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL rst_ack0 got=%b exp=0", ack0); end
    total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL rst_ack1 got=%b exp=0", ack1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    total++; if (OEb !== 1'b1) begin bad++; $display("FAIL rst_oeb got=%b exp=1", OEb); end
    total++; if (WEb_lo !== 1'b1) begin bad++; $display("FAIL rst_weblo got=%b exp=1", WEb_lo); end
    total++; if (WEb_hi !== 1'b1) begin bad++; $display("FAIL rst_webhi got=%b exp=1", WEb_hi); end
    total++; if (le_lo !== 1'b0) begin bad++; $display("FAIL rst_lelo got=%b exp=0", le_lo); end
    total++; if (le_hi !== 1'b0) begin bad++; $display("FAIL rst_lehi got=%b exp=0", le_hi); end
    total++; if (bus_out !== 16'h0) begin bad++; $display("FAIL rst_bus got=%h exp=0", bus_out); end
    total++; if (bus_dir !== 1'b1) begin bad++; $display("FAIL rst_dir got=%b exp=1", bus_dir); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_word_read();
    logic [15:0] seq[$];
    int n, oe_n;
    bit got;
    seq = {};
    n = 0; oe_n = 0; got = 0;
    req0 = 1'b1; addr0 = 32'h0000_1234; we0 = 1'b0;
    size0 = 2'd2; bus_in = 16'hBEEF;
    while (!got && n < 40) begin
      cyc();
      n++;
      if (le_lo || le_hi) begin
        seq.push_back(bus_out);
        total++; if (bus_dir !== 1'b0) begin bad++; $display("FAIL wr_dir_addr got=%b exp=0", bus_dir); end
      end
      if (!OEb) oe_n++;
      if (le_lo && bus_out == 16'h091B) bus_in = 16'hCAFE;
      if (ack0) got = 1;
    end
    req0 = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL wr_ack got=timeout exp=ack0"); end
    total++; if (n != LAT_W - 1) begin bad++; $display("FAIL wr_lat got=%0d exp=%0d", n + 1, LAT_W); end
    total++; if (rdata !== 32'hCAFE_BEEF) begin bad++; $display("FAIL wr_rdata got=%h exp=cafebeef", rdata); end
    total++; if (oe_n != 2 * (1 + W)) begin bad++; $display("FAIL wr_oe got=%0d exp=%0d", oe_n, 2 * (1 + W)); end
    total++; if (seq.size() != 3) begin bad++; $display("FAIL wr_nseq got=%0d exp=3", seq.size()); end
    if (seq.size() == 3) begin
      total++; if (seq[0] !== 16'h091A) begin bad++; $display("FAIL wr_a0 got=%h exp=091a", seq[0]); end
      total++; if (seq[1] !== 16'h0000) begin bad++; $display("FAIL wr_a1 got=%h exp=0000", seq[1]); end
      total++; if (seq[2] !== 16'h091B) begin bad++; $display("FAIL wr_a2 got=%h exp=091b", seq[2]); end
    end
    cyc();
  endtask

  task automatic test_byte_write();
    int n, web_n, stray;
    bit got;
    n = 0; web_n = 0; stray = 0; got = 0;
    req1 = 1'b1; addr1 = 32'h0000_0003; we1 = 1'b1;
    size1 = 2'd0; wdata1 = 32'h0000_005A;
    while (!got && n < 40) begin
      cyc();
      n++;
      if (!WEb_lo || !WEb_hi) begin
        web_n++;
        total++; if (bus_out !== 16'h5A00) begin bad++; $display("FAIL bw_bus got=%h exp=5a00", bus_out); end
        total++; if ({WEb_hi, WEb_lo} !== 2'b01) begin bad++; $display("FAIL bw_web got=%b%b exp=01", WEb_hi, WEb_lo); end
        total++; if (bus_dir !== 1'b0) begin bad++; $display("FAIL bw_dir got=%b exp=0", bus_dir); end
      end
      if (ack0) stray++;
      if (ack1) got = 1;
    end
    req1 = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL bw_ack got=timeout exp=ack1"); end
    total++; if (n != LAT_BH - 1) begin bad++; $display("FAIL bw_lat got=%0d exp=%0d", n + 1, LAT_BH); end
    total++; if (web_n != 1 + W) begin bad++; $display("FAIL bw_webn got=%0d exp=%0d", web_n, 1 + W); end
    total++; if (stray != 0) begin bad++; $display("FAIL bw_ack0 got=%0d exp=0", stray); end
    cyc();
  endtask

  task automatic test_half_read();
    int n;
    bit got;
    logic [15:0] a_lo;
    n = 0; got = 0; a_lo = 16'hFFFF;
    req0 = 1'b1; addr0 = 32'h0000_0011; we0 = 1'b0;
    size0 = 2'd1; bus_in = 16'h1357;
    while (!got && n < 40) begin
      cyc();
      n++;
      if (le_lo) a_lo = bus_out;
      if (ack0) got = 1;
    end
    req0 = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL hr_ack got=timeout exp=ack0"); end
    total++; if (n != LAT_BH - 1) begin bad++; $display("FAIL hr_lat got=%0d exp=%0d", n + 1, LAT_BH); end
    total++; if (rdata !== 32'h0000_1357) begin bad++; $display("FAIL hr_rdata got=%h exp=00001357", rdata); end
    total++; if (a_lo !== 16'h0008) begin bad++; $display("FAIL hr_alo got=%h exp=0008", a_lo); end
    cyc();
  endtask

  task automatic test_byte_read();
    int n;
    bit got;
    n = 0; got = 0;
    req1 = 1'b1; addr1 = 32'h0000_0021; we1 = 1'b0;
    size1 = 2'd0; bus_in = 16'hAB34;
    while (!got && n < 40) begin
      cyc();
      n++;
      if (ack1) got = 1;
    end
    req1 = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL br_ack got=timeout exp=ack1"); end
    total++; if (rdata !== 32'h0000_00AB) begin bad++; $display("FAIL br_rdata got=%h exp=000000ab", rdata); end
    cyc();
  endtask

  task automatic test_round_robin();
    int order[$];
    int gaps[$];
    int n, ovl, run;
    n = 0; ovl = 0; run = 0;
    order = {}; gaps = {};
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    addr0 = 32'h2; addr1 = 32'h4;
    we0 = 1'b0; we1 = 1'b0;
    size0 = 2'd0; size1 = 2'd0;
    bus_in = 16'h0;
    req0 = 1'b1; req1 = 1'b1;
    while (order.size() < 4 && n < 80) begin
      cyc();
      n++;
      if (order.size() > 0) begin
        if (!busy) run++;
        else if (run > 0) begin
          gaps.push_back(run);
          run = 0;
        end
      end
      if (ack0 && ack1) ovl++;
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    total++; if (order.size() != 4) begin bad++; $display("FAIL rr_n got=%0d exp=4", order.size()); end
    total++; if (ovl != 0) begin bad++; $display("FAIL rr_ovl got=%0d exp=0", ovl); end
    for (int i = 0; i < order.size(); i++) begin
      total++; if (order[i] != i % 2) begin bad++; $display("FAIL rr_gnt%0d got=%0d exp=%0d", i, order[i], i % 2); end
    end
    total++; if (gaps.size() != 3) begin bad++; $display("FAIL rr_ngap got=%0d exp=3", gaps.size()); end
    for (int i = 0; i < gaps.size(); i++) begin
      total++; if (gaps[i] != 1) begin bad++; $display("FAIL rr_gap%0d got=%0d exp=1", i, gaps[i]); end
    end
    cyc();
  endtask

  task automatic test_mid_reset();
    int n, stray;
    bit hit, got;
    n = 0; stray = 0; hit = 0; got = 0;
    req0 = 1'b1; addr0 = 32'h0000_0040; we0 = 1'b1;
    size0 = 2'd2; wdata0 = 32'h1122_3344;
    while (!hit && n < 20) begin
      cyc();
      n++;
      if (!WEb_lo) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("FAIL mr_dlo got=timeout exp=web_lo_low"); end
    total++; if (bus_out !== 16'h3344) begin bad++; $display("FAIL mr_bus got=%h exp=3344", bus_out); end
    rst = 1'b1;
    req0 = 1'b0;
    cyc();
    total++; if ({WEb_hi, WEb_lo} !== 2'b11) begin bad++; $display("FAIL mr_web got=%b%b exp=11", WEb_hi, WEb_lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%b exp=0", busy); end
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL mr_ack got=%b exp=0", ack0); end
    rst = 1'b0;
    cyc();
    if (ack0) stray++;
    cyc();
    if (ack0) stray++;
    total++; if (stray != 0) begin bad++; $display("FAIL mr_stray got=%0d exp=0", stray); end
    req0 = 1'b1; addr0 = 32'h0; we0 = 1'b0;
    size0 = 2'd0; bus_in = 16'h00C3;
    n = 0;
    while (!got && n < 40) begin
      cyc();
      n++;
      if (ack0) got = 1;
    end
    req0 = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL mr_ack2 got=timeout exp=ack0"); end
    total++; if (n != LAT_BH - 1) begin bad++; $display("FAIL mr_lat got=%0d exp=%0d", n + 1, LAT_BH); end
    total++; if (rdata !== 32'h0000_00C3) begin bad++; $display("FAIL mr_rdata got=%h exp=000000c3", rdata); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_half_read();
    test_byte_read();
    test_round_robin();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
